// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO block: register map offsets, port stride and parameter limits.
package gpio_pkg;

   localparam int unsigned PortStride = 4;
   localparam int unsigned MaxPorts   = 4;
   localparam int unsigned MaxWidth   = 8;

   typedef enum logic [1:0] {
      RegData = 2'd0,
      RegDdr  = 2'd1,
      RegIen  = 2'd2,
      RegIflg = 2'd3
   } reg_off_e;

   // First address past the last implemented port.
   function automatic logic [8:0] addr_limit(input int unsigned ports);
      return 9'(PortStride * ports);
   endfunction

endpackage

// File: rtl/gpio_port.sv
// One GPIO port: output latch, DDR, interrupt enable/flag, 2-flop input synchronizer
// and rising-edge detection.
module gpio_port
   import gpio_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pin_in,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_en,
   input  logic [1:0]       wr_sel,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] rd_ddr,
   output logic [WIDTH-1:0] rd_ien,
   output logic [WIDTH-1:0] rd_iflg,
   output logic [WIDTH-1:0] pin_out,
   output logic [WIDTH-1:0] pin_oe,
   output logic             irq_pend
);

   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] ddr_q, ddr_d;
   logic [WIDTH-1:0] ien_q, ien_d;
   logic [WIDTH-1:0] iflg_q, iflg_d;
   logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
   logic [1:0]       arm_q, arm_d;
   logic [WIDTH-1:0] rise;

   always_comb begin
      data_d = data_q;
      ddr_d  = ddr_q;
      ien_d  = ien_q;
      iflg_d = iflg_q;
      // Edges only count once both sync2 and prev hold real post-reset samples.
      arm_d  = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
      rise   = (arm_q == 2'd3) ? (sync2_q & ~prev_q) : '0;
      if (wr_en) begin
         unique case (reg_off_e'(wr_sel))
            RegData: data_d = wr_data;
            RegDdr:  ddr_d  = wr_data;
            RegIen:  ien_d  = wr_data;
            RegIflg: iflg_d = iflg_q & ~wr_data;
         endcase
      end
      // A new edge wins over a simultaneous clear.
      iflg_d = iflg_d | (rise & ien_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q  <= '0;
         ddr_q   <= '0;
         ien_q   <= '0;
         iflg_q  <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         arm_q   <= 2'd0;
      end else begin
         data_q  <= data_d;
         ddr_q   <= ddr_d;
         ien_q   <= ien_d;
         iflg_q  <= iflg_d;
         sync1_q <= pin_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         arm_q   <= arm_d;
      end
   end

   assign rd_data  = (data_q & ddr_q) | (sync2_q & ~ddr_q);
   assign rd_ddr   = ddr_q;
   assign rd_ien   = ien_q;
   assign rd_iflg  = iflg_q;
   assign pin_out  = data_q;
   assign pin_oe   = ddr_q;
   assign irq_pend = |(iflg_q & ien_q);

endmodule

// File: rtl/gpio_chip.sv
// GPIO controller: PORTS identical ports on a byte-wide CPU bus with a registered,
// OR-able read port and a combined registered interrupt request.
module gpio_chip
   import gpio_pkg::*;
#(
   parameter int unsigned PORTS = 2,
   parameter int unsigned WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             AB,
   input  logic [7:0]             DI,
   output logic [7:0]             DO,
   input  logic                   CS,
   input  logic                   WE,
   input  logic [PORTS*WIDTH-1:0] pin_in,
   output logic [PORTS*WIDTH-1:0] pin_out,
   output logic [PORTS*WIDTH-1:0] pin_oe,
   output logic                   IRQ
);

   localparam logic [8:0] AddrLimit = addr_limit(PORTS);

   logic                        addr_hit;
   logic [5:0]                  port_sel;
   logic [PORTS-1:0]            wr_en;
   logic [PORTS-1:0][WIDTH-1:0] data_rd, ddr_rd, ien_rd, iflg_rd;
   logic [PORTS-1:0]            irq_pend;
   logic [WIDTH-1:0]            rd_word;
   logic [7:0]                  do_d, do_q;
   logic                        irq_d, irq_q;

   assign addr_hit = {1'b0, AB} < AddrLimit;
   assign port_sel = AB[7:2];

   for (genvar p = 0; p < PORTS; p++) begin : g_port
      assign wr_en[p] = CS & WE & addr_hit & (port_sel == 6'(p));

      gpio_port #(
         .WIDTH(WIDTH)
      ) u_port (
         .clk      (clk),
         .reset    (reset),
         .pin_in   (pin_in[p*WIDTH +: WIDTH]),
         .wr_data  (DI[WIDTH-1:0]),
         .wr_en    (wr_en[p]),
         .wr_sel   (AB[1:0]),
         .rd_data  (data_rd[p]),
         .rd_ddr   (ddr_rd[p]),
         .rd_ien   (ien_rd[p]),
         .rd_iflg  (iflg_rd[p]),
         .pin_out  (pin_out[p*WIDTH +: WIDTH]),
         .pin_oe   (pin_oe[p*WIDTH +: WIDTH]),
         .irq_pend (irq_pend[p])
      );
   end

   always_comb begin
      rd_word = '0;
      for (int p = 0; p < PORTS; p++) begin
         if (port_sel == 6'(p)) begin
            unique case (reg_off_e'(AB[1:0]))
               RegData: rd_word = data_rd[p];
               RegDdr:  rd_word = ddr_rd[p];
               RegIen:  rd_word = ien_rd[p];
               RegIflg: rd_word = iflg_rd[p];
            endcase
         end
      end
      // Idle cycles return zero so DO can be OR-ed onto the shared read bus.
      do_d  = (CS && !WE && addr_hit) ? 8'(rd_word) : 8'h00;
      irq_d = |irq_pend;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         do_q  <= 8'h00;
         irq_q <= 1'b0;
      end else begin
         do_q  <= do_d;
         irq_q <= irq_d;
      end
   end

   assign DO  = do_q;
   assign IRQ = irq_q;

endmodule

// File: tb/tb_gpio_chip.sv
// Randomized bench for gpio_chip against a register-map reference model, plus a
// narrow-width instance for the unimplemented-bit behaviour.
module tb_gpio_chip;

   localparam int P = 2;
   localparam int W = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    AB, DI, DO, DO2;
   logic          CS, WE, IRQ, IRQ2;
   logic [15:0]   pin_in, pin_out, pin_oe;
   logic [3:0]    pin_in2, pin_out2, pin_oe2;

   always #5 clk = ~clk;

   gpio_chip #(.PORTS(2), .WIDTH(8)) dut (
      .clk(clk), .reset(reset), .AB(AB), .DI(DI), .DO(DO), .CS(CS), .WE(WE),
      .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .IRQ(IRQ)
   );

   gpio_chip #(.PORTS(1), .WIDTH(4)) dut_w4 (
      .clk(clk), .reset(reset), .AB(AB), .DI(DI), .DO(DO2), .CS(CS), .WE(WE),
      .pin_in(pin_in2), .pin_out(pin_out2), .pin_oe(pin_oe2), .IRQ(IRQ2)
   );

   // Reference model: register contents plus a history of sampled pin words
   // (newest first); the synchronized view lags the pins by two samples.
   logic [7:0]  m_data[P], m_ddr[P], m_ien[P], m_iflg[P];
   logic [7:0]  m_do;
   logic        m_irq;
   logic [15:0] pin_hist[$];
   int          checks = 0;
   int          errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int q = 0; q < P; q++) begin
         m_data[q] = 8'h00; m_ddr[q] = 8'h00; m_ien[q] = 8'h00; m_iflg[q] = 8'h00;
      end
      m_do  = 8'h00;
      m_irq = 1'b0;
      pin_hist.delete();
   endfunction

   task automatic check_outputs();
      logic [15:0] exp_out, exp_oe;
      for (int q = 0; q < P; q++) begin
         exp_out[q*W +: W] = m_data[q];
         exp_oe[q*W +: W]  = m_ddr[q];
      end
      check_eq("DO", {24'd0, DO}, {24'd0, m_do});
      check_eq("IRQ", {31'd0, IRQ}, {31'd0, m_irq});
      check_eq("pin_out", {16'd0, pin_out}, {16'd0, exp_out});
      check_eq("pin_oe", {16'd0, pin_oe}, {16'd0, exp_oe});
   endtask

   // One clock: predict from pre-edge state and inputs, then compare after the edge.
   task automatic step();
      logic [15:0] s, pv, rise, pin_now;
      logic [7:0]  sp, clr, nx_do;
      logic [7:0]  nx_iflg[P];
      logic        nx_irq, valid, wr;
      int          p, o;
      s     = (pin_hist.size() >= 2) ? pin_hist[1] : 16'h0;
      pv    = (pin_hist.size() >= 3) ? pin_hist[2] : 16'h0;
      rise  = (pin_hist.size() >= 3) ? (s & ~pv) : 16'h0;
      p     = int'(AB) / 4;
      o     = int'(AB) % 4;
      valid = AB < 8'd8;
      wr    = CS && WE && valid;
      nx_do = 8'h00;
      if (CS && !WE && valid) begin
         sp = s[p*W +: W];
         case (o)
            0:       nx_do = (m_data[p] & m_ddr[p]) | (sp & ~m_ddr[p]);
            1:       nx_do = m_ddr[p];
            2:       nx_do = m_ien[p];
            default: nx_do = m_iflg[p];
         endcase
      end
      nx_irq = 1'b0;
      for (int q = 0; q < P; q++) begin
         nx_irq     = nx_irq | (|(m_iflg[q] & m_ien[q]));
         clr        = (wr && p == q && o == 3) ? DI : 8'h00;
         nx_iflg[q] = (m_iflg[q] & ~clr) | (rise[q*W +: W] & m_ien[q]);
      end
      pin_now = pin_in;
      @(posedge clk);
      #1;
      for (int q = 0; q < P; q++) m_iflg[q] = nx_iflg[q];
      if (wr) begin
         case (o)
            0:       m_data[p] = DI;
            1:       m_ddr[p]  = DI;
            2:       m_ien[p]  = DI;
            default: ;
         endcase
      end
      m_do  = nx_do;
      m_irq = nx_irq;
      pin_hist.push_front(pin_now);
      if (pin_hist.size() > 3) void'(pin_hist.pop_back());
      check_outputs();
   endtask

   task automatic idle(input int n);
      CS = 1'b0; WE = 1'b0;
      repeat (n) step();
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      CS = 1'b1; WE = 1'b1; AB = a; DI = d;
      step();
      CS = 1'b0; WE = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a);
      CS = 1'b1; WE = 1'b0; AB = a;
      step();
      CS = 1'b0;
   endtask

   // Assert reset mid-cycle, hold it over two edges, release away from the edge.
   task automatic reset_mid();
      #3;
      reset = 1'b0;
      model_reset();
      #1;
      check_outputs();
      repeat (2) @(posedge clk);
      CS = 1'b0; WE = 1'b0;
      @(negedge clk);
      check_outputs();
      reset = 1'b1;
   endtask

   initial begin
      bit seen;
      reset = 1'b1; CS = 1'b0; WE = 1'b0; AB = 8'h00; DI = 8'h00;
      pin_in = 16'h0000; pin_in2 = 4'h0;
      model_reset();
      reset_mid();
      idle(3);

      // Direction / latch / readback mix
      pin_in[7:0] = 8'h3C;
      wr(8'h01, 8'hF0);
      wr(8'h00, 8'hA5);
      idle(3);
      check_eq("oe0", {24'd0, pin_oe[7:0]}, 32'hF0);
      check_eq("out0", {24'd0, pin_out[7:0]}, 32'hA5);
      rd(8'h00);
      check_eq("data0_read", {24'd0, DO}, 32'hAC);

      // Rising edge on pin 8 with IEN1 bit 0 set
      wr(8'h06, 8'h01);
      pin_in[8] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
         step();
         seen = IRQ;
      end
      check_eq("irq_within_4", {31'd0, seen}, 32'd1);
      rd(8'h07);
      check_eq("iflg1_set", {24'd0, DO}, 32'h01);
      wr(8'h07, 8'h01);
      idle(1);
      check_eq("irq_cleared", {31'd0, IRQ}, 32'd0);

      // Re-arm the flag, then clear it in the very cycle a new edge lands
      pin_in[8] = 1'b0; idle(3);
      pin_in[8] = 1'b1; idle(4);
      pin_in[8] = 1'b0; idle(3);
      pin_in[8] = 1'b1; idle(2);
      wr(8'h07, 8'h01);
      rd(8'h07);
      check_eq("iflg_set_wins", {24'd0, DO}, 32'h01);
      check_eq("irq_holds", {31'd0, IRQ}, 32'd1);

      // Out-of-range and deselected accesses
      rd(8'h08);
      check_eq("rd_oob", {24'd0, DO}, 32'h00);
      AB = 8'h01; WE = 1'b0; CS = 1'b0;
      step();
      check_eq("rd_no_cs", {24'd0, DO}, 32'h00);
      wr(8'h09, 8'hFF);
      for (int a = 0; a < 8; a++) rd(8'(a));

      // Narrow instance ignores DDR bits above its width
      wr(8'h01, 8'hFF);
      rd(8'h01);
      check_eq("w4_ddr_read", {24'd0, DO2}, 32'h0F);
      check_eq("w4_oe", {28'd0, pin_oe2}, 32'h0F);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) pin_in = 16'($urandom);
         AB = 8'($urandom_range(0, 9));
         DI = 8'($urandom);
         CS = 1'($urandom);
         WE = 1'($urandom);
         step();
      end

      // Reset during a write with every pin high; no spurious flag afterwards
      pin_in = 16'hFFFF;
      CS = 1'b1; WE = 1'b1; AB = 8'h01; DI = 8'hFF;
      reset_mid();
      check_eq("oe_after_reset", {16'd0, pin_oe}, 32'h0);
      wr(8'h02, 8'hFF);
      wr(8'h06, 8'hFF);
      idle(4);
      rd(8'h03);
      check_eq("iflg0_no_spurious", {24'd0, DO}, 32'h00);
      rd(8'h07);
      check_eq("iflg1_no_spurious", {24'd0, DO}, 32'h00);
      check_eq("irq_after_reset", {31'd0, IRQ}, 32'd0);

      // More random traffic after the second reset
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 2) == 0) pin_in = 16'($urandom);
         AB = 8'($urandom_range(0, 9));
         DI = 8'($urandom);
         CS = 1'($urandom);
         WE = 1'($urandom);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
